// File: rtl/crc_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_ram_pkg
// Description : Shared types, constants and the byte-wise CRC-16/CCITT-FALSE
//               step used by the CRC buffer RAM reader.
// Contents    : state_t and c_ST_* state encodings, CRC_POLY_DEFAULT,
//               CRC_INIT_DEFAULT, crc16_byte_step().
// Revision    : 1.0 - initial release
// ============================================================================
package crc_ram_pkg;

    localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_ISSUE = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    // MSB-first, unreflected, no final XOR: the byte enters the top of the
    // register and eight polynomial divisions follow.
    function automatic logic [15:0] crc16_byte_step(
        input logic [15:0] crc,
        input logic [7:0]  data_byte,
        input logic [15:0] poly
    );
        logic [15:0] v_crc;
        v_crc = crc ^ {data_byte, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (v_crc[15]) begin
                v_crc = {v_crc[14:0], 1'b0} ^ poly;
            end else begin
                v_crc = {v_crc[14:0], 1'b0};
            end
        end
        return v_crc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_ram_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : crc_ram_valid_pipe
// Description : DEPTH-deep shift register tracking which issued reads have
//               readdata arriving. A 1 pushed with an address emerges on
//               o_valid exactly when the RAM presents the matching byte.
// Ports       : clk, rst_n (async active-low), i_push (read issued this
//               cycle), o_valid (readdata valid this cycle), o_empty (no read
//               remains in flight once the current edge has been taken).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_ram_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    output logic o_valid,
    output logic o_empty
);

    logic [DEPTH-1:0] r_stages;
    logic [DEPTH-1:0] w_next;

    generate
        if (DEPTH == 1) begin : g_single
            assign w_next = i_push;
        end else begin : g_multi
            assign w_next = {r_stages[DEPTH-2:0], i_push};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages <= w_next;
        end
    end

    assign o_valid = r_stages[DEPTH-1];
    // Looks one edge ahead so the controller can leave DRAIN on the same
    // edge that consumes the last byte.
    assign o_empty = ~|w_next;

endmodule
`default_nettype wire

// File: rtl/crc_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : crc_ram_reader
// Description : Avalon-MM read master on one port of the CRC buffer RAM.
//               Streams a contiguous byte range (wrapping modulo the address
//               space) at one read per cycle and computes CRC-16/CCITT-FALSE.
// Ports       : clk_clk, reset_reset_n (async active-low)
//               start, base_addr, length       - request
//               busy, done, crc_out            - status / result
//               mem_address, mem_chipselect, mem_clken, mem_write,
//               mem_writedata, mem_readdata    - RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module crc_ram_reader
    import crc_ram_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          DATA_W       = 8,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] CRC_POLY     = CRC_POLY_DEFAULT,
    parameter logic [15:0] CRC_INIT     = CRC_INIT_DEFAULT
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crc_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [ADDR_W:0]   c_MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_cs;
    // Reads still to issue after the one currently on the bus.
    logic [ADDR_W:0]   r_remaining;
    logic [15:0]       r_crc;
    logic [15:0]       r_crc_out;

    logic [ADDR_W:0]   w_len;
    logic              w_pipe_valid;
    logic              w_pipe_empty;
    logic [15:0]       w_crc_next;

    assign w_len = (length > c_MAX_LEN) ? c_MAX_LEN : length;

    crc_ram_valid_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_valid_pipe (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_push  (r_mem_cs),
        .o_valid (w_pipe_valid),
        .o_empty (w_pipe_empty)
    );

    assign w_crc_next = w_pipe_valid ? crc16_byte_step(r_crc, mem_readdata, CRC_POLY)
                                     : r_crc;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state       <= c_ST_IDLE;
            r_mem_address <= '0;
            r_mem_cs      <= 1'b0;
            r_remaining   <= '0;
            r_crc         <= CRC_INIT;
            r_crc_out     <= CRC_INIT;
        end else begin
            r_crc <= w_crc_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mem_address <= base_addr;
                        r_remaining   <= w_len - c_LEN_ONE;
                        r_crc         <= CRC_INIT;
                        if (w_len != '0) begin
                            r_mem_cs <= 1'b1;
                            r_state  <= c_ST_ISSUE;
                        end else begin
                            r_crc_out <= CRC_INIT;
                            r_state   <= c_ST_DONE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (r_remaining == '0) begin
                        r_mem_cs <= 1'b0;
                        r_state  <= c_ST_DRAIN;
                    end else begin
                        r_mem_address <= r_mem_address + c_ADDR_ONE;
                        r_remaining   <= r_remaining - c_LEN_ONE;
                    end
                end
                c_ST_DRAIN: begin
                    // The final byte folds in on this same edge, so capture
                    // the post-update value for the result.
                    if (w_pipe_empty) begin
                        r_crc_out <= w_crc_next;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state != c_ST_IDLE);
    assign done           = (r_state == c_ST_DONE);
    assign crc_out        = r_crc_out;
    assign mem_address    = r_mem_address;
    assign mem_chipselect = r_mem_cs;
    assign mem_clken      = busy;
    assign mem_write      = 1'b0;
    assign mem_writedata  = '0;

endmodule
`default_nettype wire

// File: tb/tb_crc_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_ram_reader
// Description : Directed self-checking bench for crc_ram_reader with
//               READ_LATENCY=1 and READ_LATENCY=2 instances on a shared
//               behavioural RAM image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_ram_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [7:0]  base;
    logic [8:0]  len;

    logic        busy1, done1, cs1, clken1, wr1;
    logic [15:0] crc1;
    logic [7:0]  addr1, wd1, rd1;
    logic        busy2, done2, cs2, clken2, wr2;
    logic [15:0] crc2;
    logic [7:0]  addr2, wd2, rd2, p2;

    logic [7:0]  ram [0:255];
    logic [7:0]  addr_log [0:299];

    int          sel;
    logic        busy_s, done_s, cs_s, clken_s;
    logic [15:0] crc_s;
    logic [7:0]  addr_s;

    int n_vec;
    int n_miss;

    always #5 clk = ~clk;

    crc_ram_reader #(.READ_LATENCY(1)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start1),
        .base_addr(base), .length(len), .busy(busy1), .done(done1),
        .crc_out(crc1), .mem_address(addr1), .mem_chipselect(cs1),
        .mem_clken(clken1), .mem_write(wr1), .mem_writedata(wd1),
        .mem_readdata(rd1)
    );

    crc_ram_reader #(.READ_LATENCY(2)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start2),
        .base_addr(base), .length(len), .busy(busy2), .done(done2),
        .crc_out(crc2), .mem_address(addr2), .mem_chipselect(cs2),
        .mem_clken(clken2), .mem_write(wr2), .mem_writedata(wd2),
        .mem_readdata(rd2)
    );

    // RAM port models: one and two cycles of read latency.
    always @(posedge clk) begin
        if (cs1 && clken1) rd1 <= ram[addr1];
        if (cs2 && clken2) p2 <= ram[addr2];
        rd2 <= p2;
    end

    always_comb begin
        busy_s  = busy1;
        done_s  = done1;
        cs_s    = cs1;
        clken_s = clken1;
        crc_s   = crc1;
        addr_s  = addr1;
        if (sel == 2) begin
            busy_s  = busy2;
            done_s  = done2;
            cs_s    = cs2;
            clken_s = clken2;
            crc_s   = crc2;
            addr_s  = addr2;
        end
    end

    task automatic set_start(input int s, input logic v);
        if (s == 2) start2 = v;
        else        start1 = v;
    endtask

    task automatic load_ascii(input logic [7:0] at);
        logic [7:0] a;
        a = at;
        for (int i = 0; i < 9; i++) begin
            ram[a] = 8'h31 + 8'(i);
            a = a + 8'd1;
        end
    endtask

    // One request; start is re-pulsed in cycles p1/p2 (0 = never) while the
    // request inputs are scrambled to prove they were latched.
    task automatic run(input int s, input logic [7:0] b, input logic [8:0] l,
                       input int p1, input int p2,
                       output int done_cyc, output int cs_cnt,
                       output int extra_done, output int clk_err,
                       output logic busy_after);
        sel = s;
        @(negedge clk);
        base = b;
        len  = l;
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        base = ~b;
        len  = 9'd1;
        done_cyc   = -1;
        cs_cnt     = 0;
        extra_done = 0;
        clk_err    = 0;
        for (int c = 1; c <= 400; c++) begin
            set_start(s, (c == p1) || (c == p2));
            if (cs_s) begin
                if (cs_cnt < 300) addr_log[cs_cnt] = addr_s;
                cs_cnt++;
            end
            if (clken_s !== busy_s) clk_err++;
            if (done_s) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        set_start(s, 1'b0);
        busy_after = busy_s;
        for (int k = 0; k < 3; k++) begin
            if (done_s) extra_done++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_vec++; if (done1 !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b want 0", done1); end
        n_vec++; if (crc1 !== 16'hFFFF) begin n_miss++; $display("FAIL reset_crc got %h want ffff", crc1); end
        n_vec++; if (cs1 !== 1'b0) begin n_miss++; $display("FAIL reset_cs got %b want 0", cs1); end
        n_vec++; if (addr1 !== 8'h00) begin n_miss++; $display("FAIL reset_addr got %h want 00", addr1); end
        n_vec++; if (clken1 !== 1'b0) begin n_miss++; $display("FAIL reset_clken got %b want 0", clken1); end
        n_vec++; if (crc2 !== 16'hFFFF) begin n_miss++; $display("FAIL reset_crc2 got %h want ffff", crc2); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_run(input string nm, input int dc, input int cc,
                             input int ed, input int ce, input logic ba,
                             input int want_dc, input int want_cc,
                             input logic [15:0] want_crc);
        n_vec++; if (dc != want_dc) begin n_miss++; $display("FAIL %s_done_cycle got %0d want %0d", nm, dc, want_dc); end
        n_vec++; if (cc != want_cc) begin n_miss++; $display("FAIL %s_cs_cycles got %0d want %0d", nm, cc, want_cc); end
        n_vec++; if (crc_s !== want_crc) begin n_miss++; $display("FAIL %s_crc got %h want %h", nm, crc_s, want_crc); end
        n_vec++; if (ed != 0) begin n_miss++; $display("FAIL %s_extra_done got %0d want 0", nm, ed); end
        n_vec++; if (ce != 0) begin n_miss++; $display("FAIL %s_clken got %0d errors want 0", nm, ce); end
        n_vec++; if (ba !== 1'b0) begin n_miss++; $display("FAIL %s_busy_after got %b want 0", nm, ba); end
    endtask

    task automatic check_addrs(input string nm, input logic [7:0] first, input int n);
        logic [7:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (addr_log[i] !== a) begin
                n_miss++;
                $display("FAIL %s_addr[%0d] got %h want %h", nm, i, addr_log[i], a);
            end
            a = a + 8'd1;
        end
    endtask

    task automatic test_ascii;
        int dc, cc, ed, ce; logic ba;
        load_ascii(8'h10);
        run(1, 8'h10, 9'd9, 0, 0, dc, cc, ed, ce, ba);
        check_run("ascii", dc, cc, ed, ce, ba, 11, 9, 16'h29B1);
        check_addrs("ascii", 8'h10, 9);
    endtask

    task automatic test_single;
        int dc, cc, ed, ce; logic ba;
        ram[0] = 8'h00;
        run(1, 8'h00, 9'd1, 0, 0, dc, cc, ed, ce, ba);
        check_run("single", dc, cc, ed, ce, ba, 3, 1, 16'hE1F0);
    endtask

    task automatic test_zero_length;
        int dc, cc, ed, ce; logic ba;
        run(1, 8'h55, 9'd0, 0, 0, dc, cc, ed, ce, ba);
        check_run("zero", dc, cc, ed, ce, ba, 1, 0, 16'hFFFF);
    endtask

    task automatic test_wrap;
        int dc, cc, ed, ce; logic ba;
        load_ascii(8'hFB);
        run(1, 8'hFB, 9'd9, 0, 0, dc, cc, ed, ce, ba);
        check_run("wrap", dc, cc, ed, ce, ba, 11, 9, 16'h29B1);
        check_addrs("wrap", 8'hFB, 9);
    endtask

    task automatic test_ignored_start;
        int dc, cc, ed, ce; logic ba;
        run(1, 8'h10, 9'd9, 4, 11, dc, cc, ed, ce, ba);
        check_run("ignstart", dc, cc, ed, ce, ba, 11, 9, 16'h29B1);
        check_addrs("ignstart", 8'h10, 9);
    endtask

    task automatic test_reset_mid;
        int late_done;
        sel = 1;
        @(negedge clk);
        base = 8'h10; len = 9'd9; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (busy1 !== 1'b1) begin n_miss++; $display("FAIL midrst_busy_before got %b want 1", busy1); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy1 !== 1'b0) begin n_miss++; $display("FAIL midrst_busy got %b want 0", busy1); end
        n_vec++; if (cs1 !== 1'b0) begin n_miss++; $display("FAIL midrst_cs got %b want 0", cs1); end
        n_vec++; if (done1 !== 1'b0) begin n_miss++; $display("FAIL midrst_done got %b want 0", done1); end
        n_vec++; if (crc1 !== 16'hFFFF) begin n_miss++; $display("FAIL midrst_crc got %h want ffff", crc1); end
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1 || busy1) late_done++;
        end
        n_vec++; if (late_done != 0) begin n_miss++; $display("FAIL midrst_after got %0d active cycles want 0", late_done); end
    endtask

    task automatic test_latency2;
        int dc, cc, ed, ce; logic ba;
        load_ascii(8'h10);
        run(2, 8'h10, 9'd9, 0, 0, dc, cc, ed, ce, ba);
        check_run("lat2", dc, cc, ed, ce, ba, 12, 9, 16'h29B1);
        check_addrs("lat2", 8'h10, 9);
    endtask

    task automatic test_clamp;
        int dc, cc, ed, ce; logic ba;
        run(1, 8'h20, 9'h1FF, 0, 0, dc, cc, ed, ce, ba);
        n_vec++; if (dc != 258) begin n_miss++; $display("FAIL clamp_done_cycle got %0d want 258", dc); end
        n_vec++; if (cc != 256) begin n_miss++; $display("FAIL clamp_cs_cycles got %0d want 256", cc); end
        n_vec++; if (addr_log[0] !== 8'h20) begin n_miss++; $display("FAIL clamp_first_addr got %h want 20", addr_log[0]); end
        n_vec++; if (addr_log[255] !== 8'h1F) begin n_miss++; $display("FAIL clamp_last_addr got %h want 1f", addr_log[255]); end
        n_vec++; if (ba !== 1'b0) begin n_miss++; $display("FAIL clamp_busy_after got %b want 0", ba); end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        sel    = 1;
        start1 = 1'b0;
        start2 = 1'b0;
        base   = 8'h00;
        len    = 9'd0;
        rst_n  = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        test_reset();
        test_ascii();
        test_single();
        test_zero_length();
        test_wrap();
        test_ignored_start();
        test_reset_mid();
        test_latency2();
        test_clamp();
        n_vec++; if (wr1 !== 1'b0 || wd1 !== 8'h00) begin n_miss++; $display("FAIL write_tie got %b/%h want 0/00", wr1, wd1); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_ram_reader.md
Name: crc_ram_reader

Overview:
- Avalon-MM read master that drives one port of the dual-port CRC buffer RAM (8-bit address, 8-bit data).
- The far side (host or packet writer) fills the buffer through the other port.
- This block streams a contiguous byte range out of the RAM, pipelined at one read per cycle, and computes CRC-16/CCITT-FALSE over it.
- The coil-driver control path uses the result to validate stored parameter frames before applying them.

Parameters:
- ADDR_W, 8, RAM address width; range wraps modulo 2**ADDR_W.
- DATA_W, 8, RAM data width; fixed at 8, because the CRC step is byte-wise.
- READ_LATENCY, 1, cycles from address/chipselect to valid readdata; legal values 1..2.
- CRC_POLY, 16'h1021, CRC polynomial, MSB-first.
- CRC_INIT, 16'hFFFF, CRC seed loaded at start.

Ports:
- clk_clk, in, 1, single clock; RAM port and block share it.
- reset_reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request; accepted only in IDLE.
- base_addr, in, ADDR_W, first byte address; sampled on accepted start.
- length, in, ADDR_W+1, byte count 0..256; sampled on accepted start; values >256 are clamped to 256.
- busy, out, 1, high from the cycle after accept until done.
- done, out, 1, one-cycle pulse when crc_out is final.
- crc_out, out, 16, CRC result; valid at done, held until next accepted start.
- mem_address, out, ADDR_W, to RAM s2 address.
- mem_chipselect, out, 1, to RAM s2 chipselect.
- mem_clken, out, 1, to RAM s2 clken; tied 1 while busy, else 0.
- mem_write, out, 1, tied 0.
- mem_writedata, out, DATA_W, tied 0.
- mem_readdata, in, DATA_W, from RAM s2 readdata.

Behaviour:
- Reset (async assert, sync deassert by the system) clears all state:
  - busy=0, done=0, crc_out=CRC_INIT, mem_address=0, mem_chipselect=0, mem_clken=0.
  - The state machine returns to IDLE and the valid pipe is cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr, latches length as remaining, loads crc=CRC_INIT.
  - Go to ISSUE if length!=0, else go to DONE.
- ISSUE:
  - Each cycle: mem_chipselect=1, mem_address=base+issued (mod 2**ADDR_W), push 1 into the valid pipe, decrement remaining.
  - After the last issue, go to DRAIN.
  - Issue is never stalled; the RAM has fixed latency.
- Valid pipe: a shift register of depth READ_LATENCY. When its output is 1, sample mem_readdata and update crc = step(crc, byte).
- step() is byte-wise and MSB-first:
  - XOR byte<<8 into crc.
  - Then 8 iterations of: shift left, XOR CRC_POLY when the shifted-out bit is 1.
  - No reflection, no final XOR.
- DRAIN: wait until the valid pipe is empty and the last update has been registered, then go to DONE.
- DONE: done=1 for exactly one cycle, crc_out<=crc, busy=0 next cycle, go to IDLE.
- Timing (start accepted in cycle 0, length L>0):
  - Addresses are driven in cycles 1..L.
  - The last data byte is consumed in cycle L+READ_LATENCY.
  - done is high in cycle L+READ_LATENCY+1.
- L=0: no chipselect ever asserts; done is high in cycle 1 with crc_out=CRC_INIT.
- start while busy or in DONE: ignored, with no effect on latched inputs.
- start in the same cycle as done: ignored; start is accepted only in IDLE.
- Address wrap: base+L beyond 255 wraps to 0 silently; there is no error.
- Reset mid-operation: everything clears immediately and done is not pulsed. The RAM sees chipselect drop asynchronously, which is safe because the block never writes.

Decomposition:
- Package crc_ram_pkg holds:
  - The state enum.
  - CRC_POLY_DEFAULT and CRC_INIT_DEFAULT.
  - A function crc16_byte_step(crc, byte, poly).
- One sub-module, crc_ram_valid_pipe: a READ_LATENCY-deep valid shift register with an empty flag.
- All other logic is flat in the top.

Test Plan:
- ASCII "123456789" preloaded at 0x10..0x18, base=0x10, length=9 -> crc_out=0x29B1, done in cycle 11 (READ_LATENCY=1), 9 contiguous chipselect cycles.
- Single byte 0x00 at 0x00, base=0x00, length=1 -> crc_out=0xE1F0, done in cycle 3.
- length=0, base=0x55 -> done in cycle 1, crc_out=0xFFFF, mem_chipselect never high.
- Wrap: "123456789" at 0xFB..0xFF,0x00..0x03, base=0xFB, length=9 -> addresses FB,FC,FD,FE,FF,00,01,02,03 and crc_out=0x29B1.
- start pulsed in cycles 4 and 11 during a length=9 run -> both ignored, single done, crc_out=0x29B1. Then reassert reset_reset_n=0 in cycle 5 of a new run -> busy, chipselect and done go to 0 immediately, crc_out=0xFFFF.
- READ_LATENCY=2 with the "123456789" case -> crc_out=0x29B1, done in cycle 12.
